// File: rtl/dual_mem_access.sv
// Dual-slot memory-access stage in front of the dual-port data RAM.
// Cycle N: decode, align-check and drive both RAM ports.
// Cycle N+1: merge same-cycle store bytes into the slot-2 load, extract and extend.
// The result is registered into wb_* and ale_*, so it is visible in cycle N+2.
module dual_mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        mem_valid_1,
    input  logic        mem_valid_2,
    input  logic [2:0]  mem_op_1,
    input  logic [2:0]  mem_op_2,
    input  logic [31:0] mem_addr_1,
    input  logic [31:0] mem_addr_2,
    input  logic [31:0] mem_wdata_1,
    input  logic [31:0] mem_wdata_2,
    input  logic [31:0] mem_pc_1,
    input  logic [31:0] mem_pc_2,
    input  logic [4:0]  mem_wreg_1,
    input  logic [4:0]  mem_wreg_2,
    output logic        ram_ce_1,
    output logic        ram_ce_2,
    output logic        ram_we_1,
    output logic        ram_we_2,
    output logic [31:0] ram_pc_1,
    output logic [31:0] ram_pc_2,
    output logic [31:0] ram_addr_1,
    output logic [31:0] ram_addr_2,
    output logic [3:0]  ram_sel_1,
    output logic [3:0]  ram_sel_2,
    output logic [31:0] ram_wdata_1,
    output logic [31:0] ram_wdata_2,
    input  logic [31:0] ram_rdata_1,
    input  logic [31:0] ram_rdata_2,
    output logic        wb_valid_1,
    output logic        wb_valid_2,
    output logic [4:0]  wb_wreg_1,
    output logic [4:0]  wb_wreg_2,
    output logic [31:0] wb_wdata_1,
    output logic [31:0] wb_wdata_2,
    output logic        ale_1,
    output logic        ale_2
);

    localparam logic [2:0] OpLb  = 3'b000;
    localparam logic [2:0] OpLbu = 3'b001;
    localparam logic [2:0] OpLh  = 3'b010;
    localparam logic [2:0] OpLhu = 3'b011;
    localparam logic [2:0] OpLw  = 3'b100;
    localparam logic [2:0] OpSb  = 3'b101;
    localparam logic [2:0] OpSh  = 3'b110;
    localparam logic [2:0] OpSw  = 3'b111;

    function automatic logic is_store(input logic [2:0] op);
        return op[2] & (|op[1:0]);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
        logic mis;
        case (op)
            OpLh, OpLhu, OpSh: mis = off[0];
            OpLw, OpSw:        mis = |off;
            default:           mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] lane_sel(input logic [2:0] op, input logic [1:0] off);
        logic [3:0] sel;
        case (op)
            OpSb:    sel = 4'b0001 << off;
            OpSh:    sel = off[1] ? 4'b1100 : 4'b0011;
            default: sel = 4'b1111;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] op, input logic [31:0] wdata);
        logic [31:0] data;
        case (op)
            OpSb:    data = {4{wdata[7:0]}};
            OpSh:    data = {2{wdata[15:0]}};
            default: data = wdata;
        endcase
        return data;
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] off,
                                            input logic [31:0] word);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        shifted = word >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? word[31:16] : word[15:0];
        case (op)
            OpLb:    res = {{24{b[7]}}, b};
            OpLbu:   res = {24'b0, b};
            OpLh:    res = {{16{h[15]}}, h};
            OpLhu:   res = {16'b0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    logic        acc_1, acc_2;
    logic        mis_1, mis_2;
    logic        go_1, go_2;
    logic        fwd_d;

    logic        s1_valid_1, s1_valid_2;
    logic        s1_load_1, s1_load_2;
    logic [2:0]  s1_op_1, s1_op_2;
    logic [1:0]  s1_off_1, s1_off_2;
    logic [4:0]  s1_wreg_1, s1_wreg_2;
    logic        s1_mis_1, s1_mis_2;
    logic        s1_fwd;
    logic [3:0]  s1_fwd_sel;
    logic [31:0] s1_fwd_data;

    logic [31:0] fwd_word;
    logic        wb_valid_d_1, wb_valid_d_2;
    logic        ale_d_1, ale_d_2;
    logic [31:0] wb_wdata_d_1, wb_wdata_d_2;

    // Request decode and RAM port drive for the current cycle
    always_comb begin
        acc_1       = mem_valid_1 & ~stall_i & ~flush_i;
        acc_2       = mem_valid_2 & ~stall_i & ~flush_i;
        mis_1       = is_misaligned(mem_op_1, mem_addr_1[1:0]);
        mis_2       = is_misaligned(mem_op_2, mem_addr_2[1:0]);
        go_1        = acc_1 & ~mis_1;
        go_2        = acc_2 & ~mis_2;
        ram_ce_1    = go_1;
        ram_ce_2    = go_2;
        ram_we_1    = go_1 & is_store(mem_op_1);
        ram_we_2    = go_2 & is_store(mem_op_2);
        ram_sel_1   = go_1 ? lane_sel(mem_op_1, mem_addr_1[1:0]) : 4'b0000;
        ram_sel_2   = go_2 ? lane_sel(mem_op_2, mem_addr_2[1:0]) : 4'b0000;
        ram_addr_1  = mem_addr_1;
        ram_addr_2  = mem_addr_2;
        ram_pc_1    = mem_pc_1;
        ram_pc_2    = mem_pc_2;
        ram_wdata_1 = lane_data(mem_op_1, mem_wdata_1);
        ram_wdata_2 = lane_data(mem_op_2, mem_wdata_2);
        // The RAM returns the pre-store word to a same-cycle reader, so the younger
        // slot-2 load must pick up the older slot-1 store bytes itself.
        fwd_d       = ram_we_1 & go_2 & ~is_store(mem_op_2)
                      & (mem_addr_1[31:2] == mem_addr_2[31:2]);
    end

    // Response register: tracks what the RAM is answering in the next cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_1  <= 1'b0;
            s1_valid_2  <= 1'b0;
            s1_load_1   <= 1'b0;
            s1_load_2   <= 1'b0;
            s1_op_1     <= 3'b000;
            s1_op_2     <= 3'b000;
            s1_off_1    <= 2'b00;
            s1_off_2    <= 2'b00;
            s1_wreg_1   <= 5'd0;
            s1_wreg_2   <= 5'd0;
            s1_mis_1    <= 1'b0;
            s1_mis_2    <= 1'b0;
            s1_fwd      <= 1'b0;
            s1_fwd_sel  <= 4'b0000;
            s1_fwd_data <= 32'd0;
        end else begin
            s1_valid_1  <= acc_1;
            s1_valid_2  <= acc_2;
            s1_load_1   <= ~is_store(mem_op_1);
            s1_load_2   <= ~is_store(mem_op_2);
            s1_op_1     <= mem_op_1;
            s1_op_2     <= mem_op_2;
            s1_off_1    <= mem_addr_1[1:0];
            s1_off_2    <= mem_addr_2[1:0];
            s1_wreg_1   <= mem_wreg_1;
            s1_wreg_2   <= mem_wreg_2;
            s1_mis_1    <= mis_1;
            s1_mis_2    <= mis_2;
            s1_fwd      <= fwd_d;
            s1_fwd_sel  <= ram_sel_1;
            s1_fwd_data <= ram_wdata_1;
        end
    end

    // Forward merge, extraction and writeback qualification; flush kills the in-flight response
    always_comb begin
        fwd_word = ram_rdata_2;
        for (int b = 0; b < 4; b++) begin
            if (s1_fwd && s1_fwd_sel[b]) begin
                fwd_word[8*b +: 8] = s1_fwd_data[8*b +: 8];
            end
        end
        wb_valid_d_1 = s1_valid_1 & s1_load_1 & ~s1_mis_1 & ~flush_i;
        wb_valid_d_2 = s1_valid_2 & s1_load_2 & ~s1_mis_2 & ~flush_i;
        ale_d_1      = s1_valid_1 & s1_mis_1 & ~flush_i;
        ale_d_2      = s1_valid_2 & s1_mis_2 & ~flush_i;
        wb_wdata_d_1 = wb_valid_d_1 ? extract(s1_op_1, s1_off_1, ram_rdata_1) : 32'd0;
        wb_wdata_d_2 = wb_valid_d_2 ? extract(s1_op_2, s1_off_2, fwd_word) : 32'd0;
    end

    // Writeback register; not frozen by stall since the RAM does not hold its read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid_1 <= 1'b0;
            wb_valid_2 <= 1'b0;
            wb_wreg_1  <= 5'd0;
            wb_wreg_2  <= 5'd0;
            wb_wdata_1 <= 32'd0;
            wb_wdata_2 <= 32'd0;
            ale_1      <= 1'b0;
            ale_2      <= 1'b0;
        end else begin
            wb_valid_1 <= wb_valid_d_1;
            wb_valid_2 <= wb_valid_d_2;
            wb_wreg_1  <= wb_valid_d_1 ? s1_wreg_1 : 5'd0;
            wb_wreg_2  <= wb_valid_d_2 ? s1_wreg_2 : 5'd0;
            wb_wdata_1 <= wb_wdata_d_1;
            wb_wdata_2 <= wb_wdata_d_2;
            ale_1      <= ale_d_1;
            ale_2      <= ale_d_2;
        end
    end

endmodule
